// File: rtl/apu_audio_resampler.sv
// ---------------------------------------------------------------------------
// apu_audio_resampler
//
// Purpose:
//   Converts the NES APU mixed-audio stream into one signed mono sample per
//   audio frame for the WM8731 driver. The unsigned input is DC-centred,
//   low-passed/decimated by a leaky integrator, scaled by a 4-bit volume
//   (volume/8, saturating) and written out as a left-then-right strobe pair.
//
// Ports:
//   clk           24 MHz system clock, single domain
//   reset         synchronous, active-high
//   sample_in     unsigned 16-bit APU mix sample
//   sample_valid  1-cycle strobe, sample_in consumed on that edge
//   volume        gain = volume/8 (8 = unity, 0 = silent)
//   mute          forces output data to 0, strobes still issued
//   write_data    signed sample to driver, stable from write_left to next frame
//   write_left    1-cycle strobe: driver latches write_data as left
//   write_right   1-cycle strobe: driver latches write_data as right
//   starved       1 = no sample_valid seen during the previous frame
//
// Handshake: there is no back-pressure in either direction. sample_valid is
// a fire-and-forget strobe consumed on the clock edge where it is high; the
// write_left/write_right strobes are likewise single-cycle and the driver is
// expected to latch write_data on them unconditionally.
// ---------------------------------------------------------------------------
module apu_audio_resampler #(
  parameter int FRAME_CLKS = 768,
  parameter int DC_OFFSET  = 32768,
  parameter int SHIFT      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sample_in,
  input  logic        sample_valid,
  input  logic [3:0]  volume,
  input  logic        mute,
  output logic [15:0] write_data,
  output logic        write_left,
  output logic        write_right,
  output logic        starved
);

  localparam int AW = 17 + SHIFT;
  localparam int CW = (FRAME_CLKS > 1) ? $clog2(FRAME_CLKS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_CLKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR_L = 2'd1,
    ST_WR_R = 2'd2
  } state_e;

  // Datapath
  logic signed [16:0]    x;
  logic signed [AW-1:0]  acc_q;
  logic signed [AW-1:0]  acc_d;
  logic signed [AW-1:0]  leak;
  logic signed [16:0]    filt;
  logic signed [20:0]    prod;
  logic [15:0]           sat;
  logic [15:0]           result;

  // Frame timing
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         cnt_d;
  logic                  tick;
  logic                  seen_q;
  logic                  seen_d;

  // FSM and registered outputs
  state_e                state_q;
  logic [15:0]           data_q;
  logic                  wl_q;
  logic                  wr_q;
  logic                  starved_q;

  // DC-centre: 17-bit signed, range -32768..32767 for the default offset.
  assign x = $signed({1'b0, sample_in} - 17'(DC_OFFSET));

  // acc >>> SHIFT truncated to 17 bits is exactly the upper slice of acc.
  assign filt = acc_q[AW-1:SHIFT];
  assign leak = {{SHIFT{acc_q[AW-1]}}, filt};

  assign acc_d = sample_valid ? (acc_q + {{SHIFT{x[16]}}, x} - leak) : acc_q;

  // 17-bit signed times 5-bit non-negative gain; |prod| < 2^20 always.
  assign prod = filt * $signed({1'b0, volume});

  // Clamp (prod >>> 3) to 16-bit signed. Comparing prod against 8x the
  // limits avoids a separate shifted copy: floor(p/8) > 32767 <=> p > 262143
  // and floor(p/8) < -32768 <=> p < -262144.
  always_comb begin
    sat = prod[18:3];
    if (prod > 21'sd262143) begin
      sat = 16'h7FFF;
    end else if (prod < -21'sd262144) begin
      sat = 16'h8000;
    end
  end

  assign result = mute ? 16'h0000 : sat;

  assign tick   = (cnt_q == LAST_CNT);
  assign cnt_d  = tick ? '0 : cnt_q + CW'(1);
  // The tick cycle clears the flag; a sample in that cycle is folded into
  // starved directly rather than carried into the next frame.
  assign seen_d = tick ? 1'b0 : (seen_q | sample_valid);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      seen_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      seen_q <= seen_d;
    end
  end

  // Output sequencer. The capture in the tick cycle uses acc as registered
  // at the start of that cycle, so a sample arriving in the tick cycle only
  // influences the following frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      wl_q      <= 1'b0;
      wr_q      <= 1'b0;
      starved_q <= 1'b0;
    end else begin
      wl_q <= 1'b0;
      wr_q <= 1'b0;
      if (tick) begin
        starved_q <= ~(seen_q | sample_valid);
      end
      case (state_q)
        ST_IDLE: begin
          if (tick) begin
            data_q  <= result;
            wl_q    <= 1'b1;
            state_q <= ST_WR_L;
          end
        end
        ST_WR_L: begin
          wr_q    <= 1'b1;
          state_q <= ST_WR_R;
        end
        ST_WR_R: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign write_data  = data_q;
  assign write_left  = wl_q;
  assign write_right = wr_q;
  assign starved     = starved_q;

endmodule

// File: tb/tb_apu_audio_resampler.sv
// ---------------------------------------------------------------------------
// tb_apu_audio_resampler
//
// Self-checking bench. A behavioural model runs on every rising edge from the
// same inputs the DUT sees; at each frame tick it pushes the expected output
// word into exp_q, and the monitor pops it when write_left appears. Strobe
// timing, starved and data hold are compared every cycle on the falling edge.
// ---------------------------------------------------------------------------
module tb_apu_audio_resampler;

  localparam int FRAME = 768;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic [3:0]  volume;
  logic        mute;
  logic [15:0] write_data;
  logic        write_left;
  logic        write_right;
  logic        starved;

  always #5 clk = ~clk;

  apu_audio_resampler #(
    .FRAME_CLKS (FRAME),
    .DC_OFFSET  (32768),
    .SHIFT      (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .volume       (volume),
    .mute         (mute),
    .write_data   (write_data),
    .write_left   (write_left),
    .write_right  (write_right),
    .starved      (starved)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] exp_q[$];
  int          m_acc;
  int          m_cnt;
  bit          m_seen;
  bit          m_wl;
  bit          m_wr;
  bit          m_starved;
  logic [15:0] m_data;

  function automatic logic [15:0] model_result(input int acc, input int vol, input bit mu);
    int f;
    int p;
    int s;
    f = acc >>> 4;          // floor(acc / 16)
    p = f * vol;
    s = p >>> 3;            // floor(p / 8)
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    if (mu) s = 0;
    return s[15:0];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_acc = 0; m_cnt = 0; m_seen = 0;
      m_wl = 0; m_wr = 0; m_starved = 0; m_data = '0;
      exp_q.delete();
    end else begin
      m_wr = m_wl;
      m_wl = 0;
      if (m_cnt == FRAME - 1) begin
        m_data    = model_result(m_acc, int'(volume), mute);
        exp_q.push_back(m_data);
        m_wl      = 1;
        m_starved = !(m_seen || sample_valid);
        m_seen    = 0;
      end else if (sample_valid) begin
        m_seen = 1;
      end
      if (sample_valid) begin
        m_acc = m_acc + (int'(sample_in) - 32768) - (m_acc >>> 4);
      end
      m_cnt = (m_cnt == FRAME - 1) ? 0 : m_cnt + 1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit mon_en = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("write_left", write_left, m_wl);
      chk("write_right", write_right, m_wr);
      chk("starved", starved, m_starved);
      chk("both_strobes", write_left & write_right, 1'b0);
      if (write_left) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_left", 1'b1, 1'b0);
        end else begin
          chk("sb_left_data", write_data, exp_q.pop_front());
        end
      end else if (write_right) begin
        chk("right_data", write_data, m_data);
      end else begin
        chk("hold_data", write_data, m_data);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Advance to the falling edge where write_left is high; n = edges waited.
  task automatic wait_left(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!write_left && n < 2000);
    if (!write_left) chk("wait_left_timeout", n, 0);
  endtask

  task automatic frames(input int k);
    int n;
    for (int i = 0; i < k; i++) wait_left(n);
  endtask

  task automatic drive_random(input int n);
    for (int i = 0; i < n; i++) begin
      sample_valid = 1'($urandom_range(0, 1));
      sample_in    = 16'($urandom_range(0, 65535));
      if (i % 500 == 0) begin
        volume = 4'($urandom_range(0, 15));
        mute   = ($urandom_range(0, 7) == 0);
      end
      @(negedge clk);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    reset = 1'b1; sample_in = '0; sample_valid = 1'b0; volume = 4'd8; mute = 1'b0;
    @(posedge clk);
    @(negedge clk);
    mon_en = 1;
    chk("reset_data", write_data, 16'h0000);
    chk("reset_left", write_left, 1'b0);
    chk("reset_starved", starved, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // 1: no samples -> first pair at cycle 768/769, data 0, starved
    wait_left(n);
    chk("t1_left_latency", n, FRAME);
    chk("t1_left_data", write_data, 16'h0000);
    chk("t1_starved", starved, 1'b1);
    @(negedge clk);
    chk("t1_right", write_right, 1'b1);
    chk("t1_right_data", write_data, 16'h0000);

    // 2: constant 0x9000 at unity gain settles to 0x1000 (0x0FFF tolerated)
    sample_in = 16'h9000; sample_valid = 1'b1; volume = 4'd8;
    frames(4);
    chk("t2_settled", (write_data == 16'h1000) || (write_data == 16'h0FFF), 1'b1);
    chk("t2_not_starved", starved, 1'b0);
    @(negedge clk);
    chk("t2_right_eq", (write_data == 16'h1000) || (write_data == 16'h0FFF), 1'b1);

    // 3: saturation both ways at volume 15
    sample_in = 16'hFFFF; volume = 4'd15;
    frames(2);
    chk("t3_sat_pos", write_data, 16'h7FFF);
    sample_in = 16'h0000;
    frames(2);
    chk("t3_sat_neg", write_data, 16'h8000);

    // 4: mute keeps strobes, zero data; unmute restores
    sample_in = 16'h9000; volume = 4'd8;
    frames(1);
    mute = 1'b1;
    wait_left(n);
    chk("t4_mute_left", write_data, 16'h0000);
    @(negedge clk);
    chk("t4_mute_right", write_right, 1'b1);
    chk("t4_mute_right_data", write_data, 16'h0000);
    mute = 1'b0;
    wait_left(n);
    chk("t4_unmute", (write_data == 16'h1000) || (write_data == 16'h0FFF), 1'b1);

    // random stimulus, model-checked
    drive_random(3 * FRAME);
    mute = 1'b0; volume = 4'd8; sample_valid = 1'b0;

    // 5: reset in the write_left cycle drops write_right
    wait_left(n);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_no_right", write_right, 1'b0);
    chk("t5_data_zero", write_data, 16'h0000);
    chk("t5_left_zero", write_left, 1'b0);
    reset = 1'b0;
    wait_left(n);
    chk("t5_left_latency", n, FRAME);

    // 6: starved tracking (frame above had no samples)
    chk("t6_starved_empty", starved, 1'b1);
    idle_cycles(100);
    sample_valid = 1'b1; sample_in = 16'hA000;
    @(negedge clk);
    sample_valid = 1'b0;
    wait_left(n);
    chk("t6_one_sample", starved, 1'b0);
    wait_left(n);
    chk("t6_starved_again", starved, 1'b1);
    // sample only in the tick cycle, which is 767 edges after write_left
    idle_cycles(FRAME - 1);
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    chk("t6_tick_left", write_left, 1'b1);
    chk("t6_tick_sample_seen", starved, 1'b0);
    idle_cycles(3);

    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
